// File: rtl/left_turn_sequencer.sv
// Left-side tail-light sequencer: inner-to-outer sweep on ena, all-lamp hazard blink on haz,
// brake lights all lamps only while idle.
// Ports: clk/rst (async active-high), ena/haz/brake requests, left_leds[2:0] (bit0 inner),
// cycle_done (one-cycle pulse after each completed L1-L2-L3 sweep).
module left_turn_sequencer #(
    parameter int STEP_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       haz,
    input  logic       brake,
    output logic [2:0] left_leds,
    output logic       cycle_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1     = 3'd1,
        L2     = 3'd2,
        L3     = 3'd3,
        HZ_ON  = 3'd4,
        HZ_OFF = 3'd5
    } state_t;

    localparam logic [8:0] LAST = 9'(STEP_TICKS - 1);

    state_t     state;
    logic [8:0] count;
    logic       wrap_pend;   // set on the L3->L1 edge, becomes cycle_done one edge later
    logic       expire;

    assign expire = (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 9'd0;
            wrap_pend  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= wrap_pend;
            wrap_pend  <= 1'b0;
            // Hazard preempts anything from a legal non-hazard state; illegal
            // encodings skip this and fall into the default arm below.
            if (haz && (state == IDLE || state == L1 || state == L2 || state == L3)) begin
                state <= HZ_ON;
                count <= 9'd0;
            end else begin
                case (state)
                    HZ_ON, HZ_OFF: begin
                        if (!haz) begin
                            // ena is deliberately not looked at here: one IDLE cycle first
                            state <= IDLE;
                            count <= 9'd0;
                        end else if (expire) begin
                            state <= (state == HZ_ON) ? HZ_OFF : HZ_ON;
                            count <= 9'd0;
                        end else begin
                            count <= count + 9'd1;
                        end
                    end
                    IDLE: begin
                        count <= 9'd0;
                        if (ena) begin
                            state <= L1;
                        end
                    end
                    L1, L2, L3: begin
                        if (!ena) begin
                            state <= IDLE;
                            count <= 9'd0;
                        end else if (expire) begin
                            count <= 9'd0;
                            case (state)
                                L1:      state <= L2;
                                L2:      state <= L3;
                                default: begin
                                    state     <= L1;
                                    wrap_pend <= 1'b1;
                                end
                            endcase
                        end else begin
                            count <= count + 9'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= 9'd0;
                    end
                endcase
            end
        end
    end

    // Pure decode of state so lamps move on the same edge as the state; brake
    // acts combinationally and only in IDLE.
    always_comb begin
        left_leds = 3'b000;
        case (state)
            IDLE:      left_leds = brake ? 3'b111 : 3'b000;
            L1:        left_leds = 3'b001;
            L2:        left_leds = 3'b011;
            L3, HZ_ON: left_leds = 3'b111;
            default:   left_leds = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_left_turn_sequencer.sv
// Bench for left_turn_sequencer with STEP_TICKS=4: directed scenarios followed by random
// request toggling, checked against a mode/elapsed-tick reference model.
// Ports driven: clk, rst, ena, haz, brake; observed: left_leds, cycle_done.
module tb_left_turn_sequencer;

    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       haz;
    logic       brake;
    logic [2:0] left_leds;
    logic       cycle_done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0=idle, 1=sweep, 2=hazard; n/m = edges since entering sweep/hazard.
    int mode = 0;
    int n = 0;
    int m = 0;
    bit pend = 1'b0;
    bit pulse = 1'b0;

    left_turn_sequencer #(.STEP_TICKS(ST)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .haz        (haz),
        .brake      (brake),
        .left_leds  (left_leds),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_leds();
        logic [2:0] pats [3];
        pats[0] = 3'b001;
        pats[1] = 3'b011;
        pats[2] = 3'b111;
        if (mode == 1) return pats[(n / ST) % 3];
        if (mode == 2) return (((m / ST) % 2) == 0) ? 3'b111 : 3'b000;
        return brake ? 3'b111 : 3'b000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode  = 0;
        n     = 0;
        m     = 0;
        pend  = 1'b0;
        pulse = 1'b0;
    endtask

    task automatic model_edge();
        bit old_pend;
        old_pend = pend;
        if (haz) begin
            if (mode != 2) begin
                mode = 2;
                m    = 0;
            end else begin
                m++;
            end
        end else if (mode == 2) begin
            mode = 0;
        end else if (mode == 0) begin
            if (ena) begin
                mode = 1;
                n    = 0;
            end
        end else if (!ena) begin
            mode = 0;
        end else begin
            n++;
        end
        pulse = old_pend;
        // a full sweep completes every 3*ST edges after the first L1
        pend = (mode == 1) && (n > 0) && ((n % (3 * ST)) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check("leds", left_leds, exp_leds());
        check("cycle_done", cycle_done, pulse);
    endtask

    task automatic apply(input logic h, input logic e, input logic b);
        haz   = h;
        ena   = e;
        brake = b;
        #1;
        check("leds_comb", left_leds, exp_leds());
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        check("rst_leds", left_leds, exp_leds());
        check("rst_cycle_done", cycle_done, 1'b0);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int k;
        bit found;
        rst   = 1'b1;
        ena   = 1'b0;
        haz   = 1'b0;
        brake = 1'b0;
        #1;
        check("reset_leds", left_leds, 3'b000);
        check("reset_cycle_done", cycle_done, 1'b0);
        tick();
        tick();
        #1 rst = 1'b0;

        // Sweep with ena held: first pulse 13 edges after the first 001
        apply(1'b0, 1'b1, 1'b0);
        tick();
        check("first_l1", left_leds, 3'b001);
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            k++;
            if (cycle_done === 1'b1) found = 1'b1;
        end
        check("first_pulse_edge", k, 13);
        for (int i = 0; i < 16; i++) tick();

        // Abort two cycles into L2
        apply(1'b0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("mid_l2", left_leds, 3'b011);
        apply(1'b0, 1'b0, 1'b0);
        tick();
        check("abort_idle", left_leds, 3'b000);
        check("abort_no_pulse", cycle_done, 1'b0);

        // Hazard with ena also high, then drop hazard
        apply(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        apply(1'b0, 1'b1, 1'b0);
        tick();
        check("haz_exit_idle", left_leds, 3'b000);
        tick();
        check("haz_exit_l1", left_leds, 3'b001);

        // Brake in idle is immediate, ignored during sweep
        apply(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        apply(1'b0, 1'b0, 1'b1);
        check("brake_on", left_leds, 3'b111);
        apply(1'b0, 1'b0, 1'b0);
        check("brake_off", left_leds, 3'b000);
        apply(1'b0, 1'b1, 1'b1);
        tick();
        check("brake_ignored", left_leds, 3'b001);

        // Async reset mid-L3, then full restart
        apply(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("in_l3", left_leds, 3'b111);
        async_reset();
        check("rst_mid_l3", left_leds, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("restart_l1", left_leds, 3'b001);
        end
        tick();
        check("restart_l2", left_leds, 3'b011);

        // Randomized request activity
        for (int i = 0; i < 600; i++) begin
            logic h, e, b;
            h = haz;
            e = ena;
            b = brake;
            if ($urandom_range(0, 24) == 0) h = ~h;
            if ($urandom_range(0, 14) == 0) e = ~e;
            if ($urandom_range(0, 3) == 0)  b = ~b;
            apply(h, e, b);
            if ($urandom_range(0, 149) == 0) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
